// File: rtl/exu_muldiv.sv
// exu_muldiv: 32-bit iterative multiply/divide execution unit.
// Shift-add multiply and restoring divide, one bit per CALC cycle, then a sign
// fix-up cycle. The result is held in DONE until writeback accepts it.
// Divide-by-zero and signed overflow skip the iteration and finish at once.
module exu_muldiv (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_muldiv_i,
   input  logic [31:0] muldiv_op1_i,
   input  logic [31:0] muldiv_op2_i,
   input  logic        muldiv_op_mul_i,
   input  logic        muldiv_op_mulh_i,
   input  logic        muldiv_op_mulhsu_i,
   input  logic        muldiv_op_mulhu_i,
   input  logic        muldiv_op_div_i,
   input  logic        muldiv_op_divu_i,
   input  logic        muldiv_op_rem_i,
   input  logic        muldiv_op_remu_i,
   input  logic [4:0]  rd_addr_i,
   input  logic        flush_i,
   output logic        ready_o,
   output logic        busy_o,
   output logic        wb_valid_o,
   input  logic        wb_ready_i,
   output logic [31:0] wb_data_o,
   output logic [4:0]  wb_rd_addr_o
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;
   typedef enum logic [2:0] {
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
      OP_DIV, OP_DIVU, OP_REM, OP_REMU
   } op_e;

   // Control and datapath registers
   state_e      state_q;
   op_e         op_q;
   logic [4:0]  cnt_q;
   logic        neg_q;
   logic [31:0] a_q;       // multiplicand or divisor magnitude
   logic [63:0] acc_q;     // {product hi, multiplier/product lo} or {remainder, dividend/quotient}
   logic [4:0]  rd_q;
   logic        wb_valid_q;
   logic [31:0] wb_data_q;
   logic [4:0]  wb_rd_q;

   // Request decode signals
   logic [7:0]  ops;
   logic        ops_onehot;
   op_e         op_sel;
   logic        op1_signed;
   logic        op2_signed;
   logic        s1;
   logic        s2;
   logic [31:0] mag1;
   logic [31:0] mag2;
   logic        neg_sel;
   logic        is_div_sel;
   logic        div_zero;
   logic        div_ovf;
   logic [31:0] special_res;
   logic        accept;

   // Iteration and fix-up signals
   logic        is_mul_q;
   logic [32:0] mul_sum;
   logic [63:0] mul_next;
   logic [32:0] div_shift;
   logic        div_ge;
   logic [31:0] div_diff;
   logic [63:0] div_next;
   logic [63:0] acc_d;
   logic [63:0] prod;
   logic [31:0] quo;
   logic [31:0] rem;
   logic [31:0] fix_res;

   // Decode the incoming request: op, operand magnitudes, result sign, shortcuts
   always_comb begin
      ops = {muldiv_op_remu_i, muldiv_op_rem_i, muldiv_op_divu_i, muldiv_op_div_i,
             muldiv_op_mulhu_i, muldiv_op_mulhsu_i, muldiv_op_mulh_i, muldiv_op_mul_i};
      ops_onehot = (ops != 8'd0) && ((ops & (ops - 8'd1)) == 8'd0);
      op_sel = OP_MUL;
      for (int unsigned i = 0; i < 8; i++) begin
         if (ops[i]) op_sel = op_e'(3'(i));
      end
      op1_signed = op_sel inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
      op2_signed = op_sel inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
      s1 = op1_signed & muldiv_op1_i[31];
      s2 = op2_signed & muldiv_op2_i[31];
      mag1 = s1 ? (32'd0 - muldiv_op1_i) : muldiv_op1_i;
      mag2 = s2 ? (32'd0 - muldiv_op2_i) : muldiv_op2_i;
      // Remainder follows the dividend sign; everything else is the sign product
      neg_sel = (op_sel == OP_REM) ? s1 : (s1 ^ s2);
      is_div_sel = op_sel inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
      div_zero = is_div_sel && (muldiv_op2_i == 32'd0);
      div_ovf = (op_sel inside {OP_DIV, OP_REM}) &&
                (muldiv_op1_i == 32'h8000_0000) && (muldiv_op2_i == 32'hFFFF_FFFF);
      special_res = '0;
      if (div_zero) begin
         special_res = (op_sel inside {OP_DIV, OP_DIVU}) ? '1 : muldiv_op1_i;
      end else if (div_ovf) begin
         special_res = (op_sel == OP_DIV) ? 32'h8000_0000 : 32'd0;
      end
      accept = (state_q == IDLE) && req_muldiv_i && ops_onehot && !flush_i;
   end

   // One multiply or divide step, plus the signed result formed in FIX
   always_comb begin
      is_mul_q = op_q inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
      mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
      mul_next = {mul_sum, acc_q[31:1]};
      div_shift = {acc_q[63:32], acc_q[31]};
      div_ge = div_shift >= {1'b0, a_q};
      // When div_ge holds the true difference is below the divisor, so 32 bits suffice
      div_diff = div_shift[31:0] - a_q;
      div_next = div_ge ? {div_diff, acc_q[30:0], 1'b1}
                        : {div_shift[31:0], acc_q[30:0], 1'b0};
      acc_d = is_mul_q ? mul_next : div_next;
      prod = neg_q ? (64'd0 - acc_q) : acc_q;
      quo = neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
      rem = neg_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
      case (op_q)
         OP_MUL:                       fix_res = prod[31:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[63:32];
         OP_DIV, OP_DIVU:              fix_res = quo;
         default:                      fix_res = rem;
      endcase
   end

   // Main FSM: accept, iterate, fix up sign, hold result until writeback handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         op_q       <= OP_MUL;
         cnt_q      <= '0;
         neg_q      <= 1'b0;
         a_q        <= '0;
         acc_q      <= '0;
         rd_q       <= '0;
         wb_valid_q <= 1'b0;
         wb_data_q  <= '0;
         wb_rd_q    <= '0;
      end else if (flush_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         wb_valid_q <= 1'b0;
         wb_data_q  <= '0;
         wb_rd_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  op_q  <= op_sel;
                  neg_q <= neg_sel;
                  rd_q  <= rd_addr_i;
                  cnt_q <= '0;
                  if (div_zero || div_ovf) begin
                     wb_valid_q <= 1'b1;
                     wb_data_q  <= special_res;
                     wb_rd_q    <= rd_addr_i;
                     state_q    <= DONE;
                  end else begin
                     a_q     <= is_div_sel ? mag2 : mag1;
                     acc_q   <= is_div_sel ? {32'd0, mag1} : {32'd0, mag2};
                     state_q <= CALC;
                  end
               end
            end
            CALC: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'd31) state_q <= FIX;
            end
            FIX: begin
               wb_valid_q <= 1'b1;
               wb_data_q  <= fix_res;
               wb_rd_q    <= rd_q;
               state_q    <= DONE;
            end
            DONE: begin
               if (wb_ready_i) begin
                  wb_valid_q <= 1'b0;
                  wb_data_q  <= '0;
                  wb_rd_q    <= '0;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ready_o      = (state_q == IDLE);
   assign busy_o       = (state_q != IDLE);
   assign wb_valid_o   = wb_valid_q;
   assign wb_data_o    = wb_data_q;
   assign wb_rd_addr_o = wb_rd_q;

endmodule

// File: tb/tb_exu_muldiv.sv
// tb_exu_muldiv: table-driven and scoreboard checks for exu_muldiv,
// plus hand sequences for flush, reset abort, backpressure and bad requests.
module tb_exu_muldiv;

   localparam int OP_MUL = 0, OP_MULH = 1, OP_MULHSU = 2, OP_MULHU = 3;
   localparam int OP_DIV = 4, OP_DIVU = 5, OP_REM = 6, OP_REMU = 7;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic [31:0] op1, op2;
   logic [7:0]  ops_v;
   logic [4:0]  rd;
   logic        flush;
   logic        ready_o, busy_o, wb_valid_o;
   logic        wb_ready;
   logic [31:0] wb_data_o;
   logic [4:0]  wb_rd_addr_o;

   always #5 clk = ~clk;

   exu_muldiv dut (
      .clk(clk), .rst(rst), .req_muldiv_i(req),
      .muldiv_op1_i(op1), .muldiv_op2_i(op2),
      .muldiv_op_mul_i(ops_v[0]), .muldiv_op_mulh_i(ops_v[1]),
      .muldiv_op_mulhsu_i(ops_v[2]), .muldiv_op_mulhu_i(ops_v[3]),
      .muldiv_op_div_i(ops_v[4]), .muldiv_op_divu_i(ops_v[5]),
      .muldiv_op_rem_i(ops_v[6]), .muldiv_op_remu_i(ops_v[7]),
      .rd_addr_i(rd), .flush_i(flush),
      .ready_o(ready_o), .busy_o(busy_o), .wb_valid_o(wb_valid_o),
      .wb_ready_i(wb_ready), .wb_data_o(wb_data_o), .wb_rd_addr_o(wb_rd_addr_o)
   );

   typedef struct {
      int          op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  rd;
      int          lat;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[17];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive_req(input int op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rdv);
      req   = 1'b1;
      ops_v = 8'd1 << op;
      op1   = a;
      op2   = b;
      rd    = rdv;
   endtask

   // Valid-looking request traffic that the unit must ignore while busy
   task automatic junk();
      req   = 1'b1;
      ops_v = 8'd1 << $urandom_range(7, 0);
      op1   = $urandom;
      op2   = $urandom;
      rd    = 5'($urandom);
   endtask

   task automatic idle_inputs();
      req   = 1'b0;
      ops_v = 8'd0;
      op1   = '0;
      op2   = '0;
      rd    = '0;
   endtask

   function automatic logic [31:0] ref_res(input int op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0]        p;
      logic signed [31:0] sa, sbv;
      logic               ovf;
      sa  = a;
      sbv = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         OP_MUL:    begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
         OP_MULH:   begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
         OP_MULHSU: begin p = {{32{a[31]}}, a} * {32'd0, b}; return p[63:32]; end
         OP_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
         OP_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sbv);
         OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
         OP_REM:    return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sbv);
         default:   return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_lat(input int op, input logic [31:0] a, input logic [31:0] b);
      if (op >= OP_DIV && b == 0) return 1;
      if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 34;
   endfunction

   // Issue one op, track it on the scoreboard, check result/latency/handshake.
   // Caller is positioned just after a rising edge with the unit idle.
   task automatic do_op(input int op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rdv, input logic [31:0] exp_d, input int exp_lat,
                        input int hold);
      exp_t e;
      int   lat;
      logic bad0;
      e.data = exp_d;
      e.rd   = rdv;
      e.lat  = exp_lat;
      sb.push_back(e);
      wb_ready = (hold == 0);
      drive_req(op, a, b, rdv);
      @(posedge clk); #1;
      chk("accept_busy", 32'(busy_o), 32'd1);
      junk();
      lat  = 1;
      bad0 = 1'b0;
      while (!wb_valid_o && lat < 200) begin
         if (wb_data_o != 0 || wb_rd_addr_o != 0) bad0 = 1'b1;
         @(posedge clk); #1;
         junk();
         lat++;
      end
      chk("outputs_zero_while_invalid", 32'(bad0), 32'd0);
      e = sb.pop_front();
      if (!wb_valid_o) begin
         checks++;
         errors++;
         $display("FAIL valid_timeout: got no wb_valid_o within %0d cycles, required one at T+%0d", lat, e.lat);
         idle_inputs();
         wb_ready = 1'b1;
         return;
      end
      chk("latency", 32'(lat), 32'(e.lat));
      chk("wb_data", wb_data_o, e.data);
      chk("wb_rd", 32'(wb_rd_addr_o), 32'(e.rd));
      for (int k = 0; k < hold; k++) begin
         chk("hold_valid", 32'(wb_valid_o), 32'd1);
         chk("hold_data", wb_data_o, e.data);
         chk("hold_rd", 32'(wb_rd_addr_o), 32'(e.rd));
         chk("hold_ready", 32'(ready_o), 32'd0);
         @(posedge clk); #1;
         junk();
      end
      wb_ready = 1'b1;
      @(posedge clk); #1;
      // A request was present in the handshake cycle; it must not have been taken
      idle_inputs();
      chk("post_hs_ready", 32'(ready_o), 32'd1);
      chk("post_hs_valid", 32'(wb_valid_o), 32'd0);
      chk("post_hs_data", wb_data_o, 32'd0);
   endtask

   initial begin
      logic seen;
      int   n;
      int   op;
      logic [31:0] a, b;

      tbl[0]  = '{OP_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 34};
      tbl[1]  = '{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, 34};
      tbl[2]  = '{OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'h0000_0000, 34};
      tbl[3]  = '{OP_DIV,    32'hFFFF_FFF9,  32'd2,         5'd3,  32'hFFFF_FFFD, 34};
      tbl[4]  = '{OP_REM,    32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFF, 34};
      tbl[5]  = '{OP_DIVU,   32'd5,          32'd0,         5'd6,  32'hFFFF_FFFF, 1};
      tbl[6]  = '{OP_REMU,   32'd5,          32'd0,         5'd7,  32'd5,         1};
      tbl[7]  = '{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd8,  32'h8000_0000, 1};
      tbl[8]  = '{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd9,  32'd0,         1};
      tbl[9]  = '{OP_DIVU,   32'd100,        32'd7,         5'd10, 32'd14,        34};
      tbl[10] = '{OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd11, 32'hFFFF_FFFF, 34};
      tbl[11] = '{OP_REMU,   32'd100,        32'd7,         5'd12, 32'd2,         34};
      tbl[12] = '{OP_DIV,    32'd0,          32'd0,         5'd13, 32'hFFFF_FFFF, 1};
      tbl[13] = '{OP_REM,    32'h8000_0000,  32'd3,         5'd14, 32'hFFFF_FFFE, 34};
      tbl[14] = '{OP_MUL,    32'h8000_0000,  32'h8000_0000, 5'd15, 32'd0,         34};
      tbl[15] = '{OP_MULH,   32'h8000_0000,  32'h8000_0000, 5'd16, 32'h4000_0000, 34};
      tbl[16] = '{OP_DIVU,   32'hFFFF_FFFF,  32'd1,         5'd17, 32'hFFFF_FFFF, 34};

      rst      = 1'b1;
      flush    = 1'b0;
      wb_ready = 1'b1;
      idle_inputs();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'(ready_o), 32'd1);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_valid", 32'(wb_valid_o), 32'd0);
      chk("rst_data", wb_data_o, 32'd0);
      chk("rst_rd", 32'(wb_rd_addr_o), 32'd0);
      rst = 1'b0;

      // Table vectors; the first one is issued in the first clock after reset
      for (int i = 0; i < 17; i++) begin
         do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].exp, tbl[i].lat, 0);
      end

      // Randomised ops against the behavioural reference
      for (int i = 0; i < 12; i++) begin
         op = $urandom_range(7, 0);
         a  = $urandom;
         b  = ($urandom_range(3, 0) == 0) ? 32'($urandom_range(15, 0)) : $urandom;
         do_op(op, a, b, 5'(i + 1), ref_res(op, a, b), ref_lat(op, a, b), 0);
      end

      // Requests with zero or multiple op flags are ignored
      req = 1'b1; ops_v = 8'd0; op1 = 32'd3; op2 = 32'd4; rd = 5'd1;
      @(posedge clk); #1;
      chk("noop_ready", 32'(ready_o), 32'd1);
      chk("noop_busy", 32'(busy_o), 32'd0);
      ops_v = 8'b0001_0001;
      @(posedge clk); #1;
      chk("multiop_ready", 32'(ready_o), 32'd1);
      idle_inputs();

      // Flush beats a simultaneous accept
      drive_req(OP_MUL, 32'd3, 32'd5, 5'd2);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      idle_inputs();
      chk("flush_vs_accept_ready", 32'(ready_o), 32'd1);

      // Flush at T+10 of a MUL, then a DIVU proceeds normally
      drive_req(OP_MUL, 32'd3, 32'd5, 5'd2);
      @(posedge clk); #1;
      idle_inputs();
      chk("flush_op_busy", 32'(busy_o), 32'd1);
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_ready_t11", 32'(ready_o), 32'd1);
      chk("flush_valid_t11", 32'(wb_valid_o), 32'd0);
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (wb_valid_o) seen = 1'b1;
         @(posedge clk); #1;
      end
      chk("flush_no_result", 32'(seen), 32'd0);
      do_op(OP_DIVU, 32'd100, 32'd7, 5'd20, 32'd14, 34, 0);

      // Backpressure: result held stable for five cycles
      do_op(OP_DIVU, 32'd100, 32'd7, 5'd21, 32'd14, 34, 5);

      // Flush beats the DONE handshake and discards the result
      wb_ready = 1'b0;
      drive_req(OP_DIVU, 32'd9, 32'd3, 5'd22);
      @(posedge clk); #1;
      idle_inputs();
      n = 0;
      while (!wb_valid_o && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("flush_hs_valid_before", 32'(wb_valid_o), 32'd1);
      flush    = 1'b1;
      wb_ready = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_hs_valid", 32'(wb_valid_o), 32'd0);
      chk("flush_hs_data", wb_data_o, 32'd0);
      chk("flush_hs_ready", 32'(ready_o), 32'd1);
      do_op(OP_REMU, 32'd9, 32'd4, 5'd23, 32'd1, 34, 0);

      // Asynchronous reset mid-operation aborts without a result
      drive_req(OP_MUL, 32'd3, 32'd5, 5'd9);
      @(posedge clk); #1;
      idle_inputs();
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("midrst_ready", 32'(ready_o), 32'd1);
      chk("midrst_busy", 32'(busy_o), 32'd0);
      chk("midrst_valid", 32'(wb_valid_o), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      do_op(OP_DIVU, 32'd100, 32'd7, 5'd24, 32'd14, 34, 0);

      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/exu_muldiv.md
EXU_MULDIV -- requirements
Module: exu_muldiv

Interface
REQ-001 No parameters; datapath width is fixed at 32 bits.
REQ-002 clk  in  1  core clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 req_muldiv_i  in  1  dispatch request from exu_dispatch.
REQ-005 muldiv_op1_i, muldiv_op2_i  in  32 each  rs1 and rs2 operand values.
REQ-006 muldiv_op_mul_i, _mulh_i, _mulhsu_i, _mulhu_i, _div_i, _divu_i, _rem_i, _remu_i  in  1 each  one-hot op select.
REQ-007 rd_addr_i  in  5  destination register tag.
REQ-008 flush_i  in  1  pipeline flush; cancels any in-flight op.
REQ-009 ready_o  out  1  unit can accept a request this cycle.
REQ-010 busy_o  out  1  op in flight or result pending.
REQ-011 wb_valid_o  out  1  result valid toward writeback.
REQ-012 wb_ready_i  in  1  writeback accepts the result.
REQ-013 wb_data_o  out  32  result.
REQ-014 wb_rd_addr_o  out  5  captured rd tag.

Function
REQ-015 States: IDLE, CALC, FIX, DONE; ready_o=1 only in IDLE; busy_o=1 in CALC/FIX/DONE.
REQ-016 Accept at cycle T when state=IDLE, req_muldiv_i=1, exactly one op flag is set, flush_i=0; operands, op and rd_addr_i are latched.
REQ-017 A request with zero or multiple op flags set is ignored; the state stays IDLE.
REQ-018 Normal path: IDLE->CALC; CALC runs 32 iterations under a 5-bit counter (cycles T+1..T+32); then FIX (T+33); then DONE, with wb_valid_o=1 from T+34.
REQ-019 Operand magnitudes: MUL/MULH/DIV/REM take the absolute value of signed op1 and op2; MULHSU takes signed op1 and unsigned op2; MULHU/DIVU/REMU take both unsigned.
REQ-020 Multiply: a shift-add over the 32-bit magnitudes gives a 64-bit product; in FIX it is negated when the result sign is negative; MUL returns [31:0], MULH/MULHSU/MULHU return [63:32].
REQ-021 Divide: a restoring algorithm, one quotient bit per CALC cycle; in FIX the quotient sign = sign(op1) XOR sign(op2), and the remainder sign = sign(op1).
REQ-022 Division by zero: IDLE->DONE directly, so wb_valid_o is asserted at T+1; DIV/DIVU result = 0xFFFFFFFF; REM/REMU result = op1.
REQ-023 Signed overflow (op1=0x80000000, op2=0xFFFFFFFF, DIV/REM): IDLE->DONE directly, valid at T+1; DIV result = 0x80000000; REM result = 0.
REQ-024 In DONE, wb_data_o and wb_rd_addr_o stay stable until wb_valid_o & wb_ready_i; on that handshake the next state is IDLE.
REQ-025 A new request cannot be accepted in the handshake cycle; the earliest next accept is the cycle after.
REQ-026 When wb_ready_i=0, DONE holds indefinitely.
REQ-027 flush_i=1 in any state: the next state is IDLE, wb_valid_o=0 next cycle, and the result is discarded.
REQ-028 flush_i has priority over accept and over the DONE handshake.
REQ-029 Inputs other than flush_i and wb_ready_i are ignored outside IDLE.
REQ-030 wb_data_o and wb_rd_addr_o are 0 whenever wb_valid_o=0.

Reset
REQ-031 While rst=1: state=IDLE, counter=0, all internal registers 0, ready_o=1, busy_o=0, wb_valid_o=0, wb_data_o=0, wb_rd_addr_o=0.
REQ-032 rst asserted mid-operation aborts immediately; no result is ever emitted for the aborted op.
REQ-033 The first accept is possible in the first clock after rst deasserts.

Verification
REQ-034 MUL op1=7, op2=0xFFFFFFFD, rd=5 -> wb_valid_o at T+34, wb_data_o=0xFFFFFFEB, wb_rd_addr_o=5.
REQ-035 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; then MULH on the same operands -> 0x00000000.
REQ-036 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD at T+34; REM on the same operands -> 0xFFFFFFFF.
REQ-037 DIVU 5/0 -> 0xFFFFFFFF at T+1; REMU 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at T+1.
REQ-038 MUL accepted, flush_i pulsed at T+10 -> no wb_valid_o; ready_o=1 at T+11; a following DIVU 100/7 -> 14.
REQ-039 DIVU 100/7 with wb_ready_i held 0 for 5 cycles after valid -> wb_data_o=14 stable throughout; ready_o=1 the cycle after the handshake.
